// File: rtl/buffer_int.sv
// Sequencer for the buffer_int transpose buffer: loads ROWS rows, reads them back
// row-wise, turns the buffer for one cycle, then reads COLS columns, with valid/ready handshakes.
module buffer_int_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 16,
  parameter int IW   = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          buf_enable,
  output logic          buf_direction,
  output logic          buf_modo_leitura,
  output logic [IW-1:0] idx,
  output logic          col_phase,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW_RD,
    S_TURN,
    S_COL_RD
  } state_t;

  localparam logic [IW-1:0] ROW_LAST = IW'(ROWS - 1);
  localparam logic [IW-1:0] COL_LAST = IW'(COLS - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d          = state_q;
    idx_d            = idx_q;
    done_d           = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    buf_enable       = 1'b0;
    buf_direction    = 1'b0;
    buf_modo_leitura = 1'b0;
    col_phase        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end

      S_LOAD: begin
        in_ready   = 1'b1;
        buf_enable = in_valid;
        if (in_valid) begin
          if (idx_q == ROW_LAST) begin
            state_d = S_ROW_RD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_ROW_RD: begin
        out_valid        = 1'b1;
        buf_modo_leitura = 1'b1;
        buf_enable       = out_ready;
        if (out_ready) begin
          if (idx_q == ROW_LAST) begin
            state_d = S_TURN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      // Single bubble cycle where the buffer switches to the column path without shifting.
      S_TURN: begin
        buf_direction    = 1'b1;
        buf_modo_leitura = 1'b1;
        state_d          = S_COL_RD;
        idx_d            = '0;
      end

      S_COL_RD: begin
        out_valid        = 1'b1;
        col_phase        = 1'b1;
        buf_direction    = 1'b1;
        buf_modo_leitura = 1'b1;
        buf_enable       = out_ready;
        if (out_ready) begin
          if (idx_q == COL_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign idx  = idx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_buffer_int_ctrl.sv
// Self-checking bench: two controllers (8x16 and 1x1) share stimulus and are compared every
// cycle against a frame-beat-counter model, plus hand-computed per-cycle expectations.
module tb_buffer_int_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  // default-size DUT
  logic       in_ready8, out_valid8, en8, dir8, modo8, colp8, busy8, done8;
  logic [4:0] idx8;
  buffer_int_ctrl #(.ROWS(8), .COLS(16), .IW(5)) dut8 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .out_ready(out_ready), .out_valid(out_valid8), .buf_enable(en8), .buf_direction(dir8),
    .buf_modo_leitura(modo8), .idx(idx8), .col_phase(colp8), .busy(busy8), .done(done8)
  );

  // minimal-size DUT
  logic       in_ready1, out_valid1, en1, dir1, modo1, colp1, busy1, done1;
  logic [4:0] idx1;
  buffer_int_ctrl #(.ROWS(1), .COLS(1), .IW(5)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .out_ready(out_ready), .out_valid(out_valid1), .buf_enable(en1), .buf_direction(dir1),
    .buf_modo_leitura(modo1), .idx(idx1), .col_phase(colp1), .busy(busy1), .done(done1)
  );

  logic [12:0] o8, o1;
  assign o8 = {in_ready8, out_valid8, en8, dir8, modo8, colp8, busy8, done8, idx8};
  assign o1 = {in_ready1, out_valid1, en1, dir1, modo1, colp1, busy1, done1, idx1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a sequence of beats k = 0 .. 2*ROWS+COLS; the phase and index follow from k.
  function automatic logic [12:0] exp_out(input int rows, input int cols, input bit act,
                                          input int k, input bit dn, input bit iv, input bit ordy);
    bit ld, rr, tn, cr;
    int ix;
    ld = act && (k < rows);
    rr = act && (k >= rows) && (k < 2 * rows);
    tn = act && (k == 2 * rows);
    cr = act && (k > 2 * rows) && (k <= 2 * rows + cols);
    ix = ld ? k : rr ? k - rows : cr ? k - 2 * rows - 1 : 0;
    return {ld, rr | cr, (ld & iv) | ((rr | cr) & ordy), tn | cr, rr | tn | cr, cr, act, dn, 5'(ix)};
  endfunction

  function automatic bit beat(input int rows, input int k, input bit iv, input bit ordy);
    if (k < rows)      return iv;
    if (k == 2 * rows) return 1'b1;
    return ordy;
  endfunction

  bit act8, dn8, act1, dn1;
  int k8, k1;
  localparam int LAST8 = 2 * 8 + 16;
  localparam int LAST1 = 2 * 1 + 1;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      act8 <= 1'b0; k8 <= 0; dn8 <= 1'b0;
      act1 <= 1'b0; k1 <= 0; dn1 <= 1'b0;
    end else begin
      dn8 <= act8 && (k8 == LAST8) && out_ready;
      if (!act8) begin
        if (start) begin act8 <= 1'b1; k8 <= 0; end
      end else if (beat(8, k8, in_valid, out_ready)) begin
        if (k8 == LAST8) act8 <= 1'b0; else k8 <= k8 + 1;
      end
      dn1 <= act1 && (k1 == LAST1) && out_ready;
      if (!act1) begin
        if (start) begin act1 <= 1'b1; k1 <= 0; end
      end else if (beat(1, k1, in_valid, out_ready)) begin
        if (k1 == LAST1) act1 <= 1'b0; else k1 <= k1 + 1;
      end
    end
  end

  always @(negedge clock) begin
    check("dut8 outputs vs model", 32'(o8), 32'(exp_out(8, 16, act8, k8, dn8, in_valid, out_ready)));
    check("dut1 outputs vs model", 32'(o1), 32'(exp_out(1, 1, act1, k1, dn1, in_valid, out_ready)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy8 && !busy1) break;
      tick();
    end
    check("idle within cycle budget", 32'({busy8, busy1}), 32'd0);
  endtask

  // mode 0 plain, 1 alternate in_valid, 2 out_ready stall, 3 start ignored/back-to-back, 4 reset mid-frame
  task automatic run_frame(input int mode, input int ncyc);
    int en_cnt = 0;
    int ld_cnt = 0;
    int exp_idx;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      in_valid  = (mode == 1) ? (c % 2 == 0) : 1'b1;
      out_ready = (mode == 2) ? !(c >= 23 && c <= 25) : 1'b1;
      start     = (mode == 3) && (c == 12 || c == 34);
      @(negedge clock);
      case (mode)
        0: begin
          exp_idx = (c <= 8) ? c - 1 : (c <= 16) ? c - 9 : (c >= 18 && c <= 33) ? c - 18 : 0;
          check("plain in_ready", 32'(in_ready8), 32'(c <= 8));
          check("plain idx", 32'(idx8), 32'(exp_idx));
          check("plain out_valid", 32'(out_valid8), 32'((c >= 9 && c <= 16) || (c >= 18 && c <= 33)));
          check("plain col_phase", 32'(colp8), 32'(c >= 18 && c <= 33));
          check("plain busy", 32'(busy8), 32'(c <= 33));
          check("plain done", 32'(done8), 32'(c == 34));
          if (c == 17) check("turn en/dir/modo/ov", 32'({en8, dir8, modo8, out_valid8}), 32'b0110);
          check("1x1 in_ready", 32'(in_ready1), 32'(c == 1));
          check("1x1 done", 32'(done1), 32'(c == 5));
          if (c == 3) check("1x1 turn dir/ov", 32'({dir1, out_valid1}), 32'b10);
        end
        1: begin
          if (c <= 16) check("gap idx hold", 32'(idx8), 32'((c - 1) / 2));
          if (in_ready8) begin
            ld_cnt++;
            if (en8) en_cnt++;
          end
          if (c == 42) check("alt done", 32'(done8), 32'd1);
        end
        2: begin
          if (c >= 23 && c <= 25) begin
            check("stall enable low", 32'(en8), 32'd0);
            check("stall idx hold", 32'(idx8), 32'd5);
          end
          check("stall done", 32'(done8), 32'(c == 37));
        end
        3: begin
          if (c == 13) check("start ignored in ROW_RD", 32'({in_ready8, out_valid8, idx8}), 32'({2'b01, 5'd4}));
          if (c == 34) check("done cycle", 32'({done8, busy8}), 32'b10);
          if (c == 35) check("back-to-back LOAD", 32'({in_ready8, busy8, idx8}), 32'({2'b11, 5'd0}));
        end
        default: begin
          if (c == 27) begin
            check("pre-reset COL_RD idx", 32'({colp8, idx8}), 32'({1'b1, 5'd9}));
            #1 reset = 1'b0;
            #1 check("async reset outputs", 32'(o8), 32'd0);
            repeat (2) @(posedge clock);
            #1 check("reset hold no done", 32'({done8, busy8}), 32'd0);
            @(negedge clock);
            #1 reset = 1'b1;
            break;
          end
        end
      endcase
      tick();
    end
    start = 1'b0;
    if (mode == 1) begin
      check("alt enable pulses", 32'(en_cnt), 32'd8);
      check("alt LOAD length", 32'(ld_cnt), 32'd16);
    end
  endtask

  initial begin
    #2 check("reset outputs dut8", 32'(o8), 32'd0);
    check("reset outputs dut1", 32'(o1), 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    tick();

    run_frame(0, 36); wait_idle(200);
    run_frame(1, 44); wait_idle(200);
    run_frame(2, 38); wait_idle(200);
    run_frame(3, 36); wait_idle(200);
    run_frame(4, 40); wait_idle(200);
    run_frame(0, 36); wait_idle(200);

    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #4 reset = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
